// File: rtl/fp32_divider_pkg.sv
// Shared FP32 divider types/constants: operand layout, class codes, FSM states.
// Combinational helpers only; no latency, no flow control.
package fp32_divider_pkg;

    localparam int QUO_BITS = 26;
    localparam int EXP_BIAS = 127;

    localparam logic [30:0] MAG_INF = 31'h7F800000;
    localparam logic [30:0] MAG_NAN = 31'h7FFFFFFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        T_NUM = 2'd0,
        T_NAN = 2'd1,
        T_ZER = 2'd2,
        T_INF = 2'd3
    } ftype_t;

    typedef enum logic [3:0] {
        ST_START, ST_EVAL1, ST_EVAL2, ST_EVAL3, ST_CHECK, ST_ELAB,
        ST_DIV, ST_NORM, ST_ROUND, ST_RANGE, ST_FINISH
    } state_t;

    // Denormals classify as zero: they are flushed, never divided.
    function automatic ftype_t classify(input fp32_t v);
        if (v.exp == 8'hFF)
            return (v.frac == 23'd0) ? T_INF : T_NAN;
        else if (v.exp == 8'h00)
            return T_ZER;
        else
            return T_NUM;
    endfunction

    function automatic ftype_t result_type(input ftype_t t1, input ftype_t t2);
        if (t1 == T_NAN || t2 == T_NAN || (t1 == T_ZER && t2 == T_ZER) ||
            (t1 == T_INF && t2 == T_INF))
            return T_NAN;
        else if (t1 == T_INF || t2 == T_ZER)
            return T_INF;
        else if (t1 == T_ZER || t2 == T_INF)
            return T_ZER;
        else
            return T_NUM;
    endfunction

    function automatic logic [30:0] pack_mag(input ftype_t t, input logic [7:0] e,
                                             input logic [22:0] m);
        case (t)
            T_ZER:   return 31'd0;
            T_INF:   return MAG_INF;
            T_NAN:   return MAG_NAN;
            default: return {e, m};
        endcase
    endfunction

endpackage

// File: rtl/fp32_divider_mant_div.sv
// Restoring mantissa divider: one quotient bit per i_step cycle, QUO_BITS steps after i_start.
// No backpressure; the controller decides when to step and watches o_last.
module fp32_mant_div
    import fp32_divider_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_step,
    input  logic [23:0]         i_m1,
    input  logic [23:0]         i_m2,
    output logic [QUO_BITS-1:0] o_q,
    output logic                o_rem_nz,
    output logic                o_last
);

    logic [24:0]         r_rem;
    logic [23:0]         r_div;
    logic [QUO_BITS-1:0] r_q;
    logic [4:0]          r_cnt;

    logic        w_ge;
    logic [24:0] w_diff;

    // rem stays below 2*divisor, so the post-subtract value fits in 24 bits before the shift.
    assign w_ge   = (r_rem >= {1'b0, r_div});
    assign w_diff = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
            r_div <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= {1'b0, i_m1};
            r_div <= i_m2;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_q   <= {r_q[QUO_BITS-2:0], w_ge};
            r_rem <= w_diff << 1;
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign o_q      = r_q;
    assign o_rem_nz = (r_rem != 25'd0);
    assign o_last   = (r_cnt == 5'(QUO_BITS - 1));

endmodule

// File: rtl/fp32_divider.sv
// Multi-cycle IEEE754 single divider, RNE, denormals flushed; done 4 edges after start (special) or 34 (numeric).
// ready is only sampled in ST_START; done is a one-cycle pulse and res holds until the next result.
module fp32_divider
    import fp32_divider_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done
);

    state_t r_state, w_next;

    fp32_t       r_op1, r_op2;
    ftype_t      r_t1, r_t2, r_type;
    logic [9:0]  r_exp;
    logic [22:0] r_mant;
    logic        r_guard, r_sticky;
    logic [31:0] r_res;
    logic        r_done;

    logic [QUO_BITS-1:0] w_q;
    logic                w_rem_nz, w_last;
    logic                w_sign, w_round_up;
    logic [23:0]         w_mant_inc;
    ftype_t              w_range_type;

    fp32_mant_div u_mant_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (r_state == ST_ELAB),
        .i_step   (r_state == ST_DIV),
        .i_m1     ({1'b1, r_op1.frac}),
        .i_m2     ({1'b1, r_op2.frac}),
        .o_q      (w_q),
        .o_rem_nz (w_rem_nz),
        .o_last   (w_last)
    );

    assign w_sign     = r_op1.sign ^ r_op2.sign;
    assign w_round_up = r_guard & (r_sticky | r_mant[0]);
    assign w_mant_inc = {1'b0, r_mant} + 24'd1;

    always_comb begin
        w_range_type = T_NUM;
        if ($signed(r_exp) <= 10'sd0)
            w_range_type = T_ZER;
        else if ($signed(r_exp) >= 10'sd255)
            w_range_type = T_INF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_START;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_START:  if (ready) w_next = ST_EVAL1;
            ST_EVAL1:  w_next = ST_EVAL2;
            ST_EVAL2:  w_next = ST_EVAL3;
            ST_EVAL3:  w_next = ST_CHECK;
            ST_CHECK:  w_next = (r_type == T_NUM) ? ST_ELAB : ST_FINISH;
            ST_ELAB:   w_next = ST_DIV;
            ST_DIV:    if (w_last) w_next = ST_NORM;
            ST_NORM:   w_next = ST_ROUND;
            ST_ROUND:  w_next = ST_RANGE;
            ST_RANGE:  w_next = ST_FINISH;
            ST_FINISH: w_next = ST_START;
            default:   w_next = ST_START;
        endcase
    end

    // res/done are registered on the edge entering ST_FINISH, so done is high exactly for that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_t1     <= T_NUM;
            r_t2     <= T_NUM;
            r_type   <= T_NUM;
            r_exp    <= '0;
            r_mant   <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_res    <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_done <= 1'b0;
                    if (ready) begin
                        r_op1 <= op1;
                        r_op2 <= op2;
                    end
                end
                ST_EVAL1: r_t1   <= classify(r_op1);
                ST_EVAL2: r_t2   <= classify(r_op2);
                ST_EVAL3: r_type <= result_type(r_t1, r_t2);
                ST_CHECK: begin
                    if (r_type != T_NUM) begin
                        r_res  <= {w_sign, pack_mag(r_type, r_exp[7:0], r_mant)};
                        r_done <= 1'b1;
                    end
                end
                ST_ELAB: r_exp <= {2'b00, r_op1.exp} - {2'b00, r_op2.exp} + 10'(EXP_BIAS);
                ST_NORM: begin
                    if (w_q[QUO_BITS-1]) begin
                        r_mant   <= w_q[24:2];
                        r_guard  <= w_q[1];
                        r_sticky <= w_q[0] | w_rem_nz;
                    end else begin
                        r_mant   <= w_q[23:1];
                        r_guard  <= w_q[0];
                        r_sticky <= w_rem_nz;
                        r_exp    <= r_exp - 10'd1;
                    end
                end
                ST_ROUND: begin
                    // A carry out leaves the low 23 bits at zero, which is the renormalised mantissa.
                    if (w_round_up) begin
                        r_mant <= w_mant_inc[22:0];
                        r_exp  <= r_exp + {9'd0, w_mant_inc[23]};
                    end
                end
                ST_RANGE: begin
                    r_res  <= {w_sign, pack_mag(w_range_type, r_exp[7:0], r_mant)};
                    r_done <= 1'b1;
                end
                ST_FINISH: r_done <= 1'b0;
                default: ;
            endcase
        end
    end

    assign res  = r_res;
    assign done = r_done;

endmodule

// File: tb/tb_fp32_divider.sv
// Directed-vector bench for fp32_divider: results, latency, reset abort, back-to-back ops.
module tb_fp32_divider;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] op1   = '0;
    logic [31:0] op2   = '0;
    logic [31:0] res;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp32_divider dut (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .op1   (op1),
        .op2   (op2),
        .res   (res),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Waits for done, returns edges counted since edge 0 (caller already passed edge 0).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        @(posedge clk);
        #2;
        op1   = a;
        op2   = b;
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, res, exp_res);
    endtask

    initial begin
        int  lat;
        logic stable;

        #12;
        chk("rst_res", res, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge clk) rst = 1'b1;

        run_op("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 34);
        run_op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 34);
        run_op("neg_third",    32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 34);
        run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 4);
        run_op("one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 4);
        run_op("neg_by_inf",   32'hBF800000, 32'h7F800000, 32'h80000000, 4);
        run_op("nan_in",       32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 4);
        run_op("overflow",     32'h7F000000, 32'h3E800000, 32'h7F800000, 34);
        run_op("underflow",    32'h00800000, 32'h40000000, 32'h00000000, 34);

        // Abort a division in flight with reset.
        @(posedge clk);
        #2;
        op1   = 32'h40C00000;
        op2   = 32'h40000000;
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_res", res, 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        @(negedge clk) rst = 1'b1;
        run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 34);

        // ready held high across two operations.
        @(posedge clk);
        #2;
        op1   = 32'h40C00000;
        op2   = 32'h40000000;
        ready = 1'b1;
        @(posedge clk);
        wait_done(lat);
        chk("hold1_lat", 32'(lat), 32'd34);
        chk("hold1_res", res, 32'h40400000);
        op1 = 32'h3F800000;
        op2 = 32'h40400000;
        @(posedge clk);
        #1;
        chk("hold_pulse_width", 32'(done), 32'h0);
        stable = (res === 32'h40400000);
        lat    = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            if (res !== 32'h40400000) stable = 1'b0;
        end
        ready = 1'b0;
        chk("hold_gap", 32'(lat), 32'd36);
        chk("hold_res_stable", 32'(stable), 32'h1);
        chk("hold2_res", res, 32'h3EAAAAAB);
        @(posedge clk);
        #1;
        chk("hold2_pulse_width", 32'(done), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
